// File: rtl/register_stack_pkg.sv
// rtl/register_stack_pkg.sv - shared widths and {WE,OE} opcode encodings for register_stack
package register_stack_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Bus operation decoded from {WE,OE}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_INV  = 2'b11
    } op_e;

endpackage

// File: rtl/register_stack_mem.sv
// rtl/register_stack_mem.sv - DEPTH x DATA_WIDTH storage, sync write/clear, comb read
module register_stack_mem
    import register_stack_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Entry storage: reset wipes every entry, otherwise a single write per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/register_stack.sv
// rtl/register_stack.sv - LIFO register stack on a shared bus; REGISTER_STACK_ERR_EN enables err
module register_stack
    import register_stack_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CS,
    input  logic                  WE,
    input  logic                  OE,
    input  logic                  PEEK,
    input  logic                  ERR_CLR,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic [PTR_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty,
    output logic                  err
);

    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_WIDTH-1:0]  sp;
    logic [PTR_WIDTH-1:0]  sp_dec;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] top_word;
    logic                  is_empty;
    logic                  is_full;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  err_event;
    op_e                   op;

    assign op       = op_e'({WE, OE});
    assign is_empty = (sp == '0);
    assign is_full  = (sp == PTR_WIDTH'(DEPTH));
    assign sp_dec   = sp - PTR_WIDTH'(1);
    assign raddr    = sp_dec[ADDR_WIDTH-1:0];

    // An empty stack presents zeros rather than a stale entry
    assign top_word = is_empty ? '0 : rdata;

    // Bus is driven only for a pure read access; a WE+OE collision leaves it released
    assign data = (CS && OE && !WE) ? top_word : 'z;

    assign push_ok = CS && (op == OP_PUSH) && !is_full;
    assign pop_ok  = CS && (op == OP_POP) && !PEEK && !is_empty;

    assign err_event = CS && (((op == OP_PUSH) && is_full) ||
                              ((op == OP_POP) && !PEEK && is_empty) ||
                              (op == OP_INV));

    register_stack_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push_ok),
        .waddr (sp[ADDR_WIDTH-1:0]),
        .wdata (data),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Stack pointer: saturating push/pop, never both in one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push_ok) begin
            sp <= sp + PTR_WIDTH'(1);
        end else if (pop_ok) begin
            sp <= sp_dec;
        end
    end

    assign count = sp;
    assign full  = is_full;
    assign empty = is_empty;

`ifdef REGISTER_STACK_ERR_EN
    logic err_q;

    // Sticky error flag; a new error event outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_event) begin
            err_q <= 1'b1;
        end else if (ERR_CLR) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    logic unused_err_inputs;

    assign unused_err_inputs = ^{ERR_CLR, err_event};
    assign err               = 1'b0;
`endif

endmodule

// File: tb/tb_register_stack.sv
// tb/tb_register_stack.sv - scoreboard and vector-table bench for register_stack
module tb_register_stack;

`ifdef REGISTER_STACK_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int PW    = $clog2(DEPTH + 1);

    typedef struct {
        logic          rst;
        logic          cs;
        logic          we;
        logic          oe;
        logic          peek;
        logic          clr;
        logic          den;
        logic [DW-1:0] din;
        logic          chk_data;
        logic [DW-1:0] exp_data;
        int            exp_count;
        logic          exp_err;
        string         name;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          cs;
    logic          we;
    logic          oe;
    logic          peek;
    logic          err_clr;
    logic          drv_en;
    logic [DW-1:0] drv_val;
    wire  [DW-1:0] data;
    logic [PW-1:0] count;
    logic          full;
    logic          empty;
    logic          err;

    int total;
    int bad;

    vec_t sb[$];
    vec_t tbl[$];

    assign data = drv_en ? drv_val : 'z;

    register_stack #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .CS      (cs),
        .WE      (we),
        .OE      (oe),
        .PEEK    (peek),
        .ERR_CLR (err_clr),
        .data    (data),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic c, input logic w, input logic o,
                                input logic p, input logic cl, input logic de,
                                input logic [DW-1:0] di, input logic ck,
                                input logic [DW-1:0] ed, input int ec, input logic ee,
                                input string nm);
        vec_t v;
        v.rst = rst; v.cs = c; v.we = w; v.oe = o; v.peek = p; v.clr = cl;
        v.den = de; v.din = di; v.chk_data = ck; v.exp_data = ed;
        v.exp_count = ec; v.exp_err = ee & ERR_ON; v.name = nm;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, compare bus mid-cycle and status after the edge
    task automatic apply(input vec_t v);
        vec_t e;
        reset   = v.rst;
        cs      = v.cs;
        we      = v.we;
        oe      = v.oe;
        peek    = v.peek;
        err_clr = v.clr;
        drv_en  = v.den;
        drv_val = v.din;
        sb.push_back(v);
        @(negedge clk);
        e = sb[0];
        if (e.chk_data) check({e.name, " data"}, int'(data), int'(e.exp_data));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.name, " count"}, int'(count), e.exp_count);
        check({e.name, " full"},  int'(full),  int'(e.exp_count == DEPTH));
        check({e.name, " empty"}, int'(empty), int'(e.exp_count == 0));
        check({e.name, " err"},   int'(err),   int'(e.exp_err));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0; cs = 1'b0; we = 1'b0; oe = 1'b0; peek = 1'b0;
        err_clr = 1'b0; drv_en = 1'b0; drv_val = '0;
        @(posedge clk);
        #1;

        // Vector table: reset, idle, fill to full, overflow, drain in LIFO order
        tbl.push_back(mk(1,0,0,0,0,0,0,8'h00, 0,8'h00, 0,0, "reset"));
        tbl.push_back(mk(0,0,0,1,0,0,1,8'h00, 1,8'h00, 0,0, "idle_cs0"));
        tbl.push_back(mk(0,1,0,0,0,0,1,8'h00, 1,8'h00, 0,0, "idle_oe0"));
        for (int i = 0; i < DEPTH; i++)
            tbl.push_back(mk(0,1,1,0,0,0,1,DW'(8'h11 * (i + 1)), 0,8'h00, i + 1,0, "push"));
        tbl.push_back(mk(0,1,1,0,0,0,1,8'hFF, 0,8'h00, DEPTH,1, "overflow"));
        for (int i = 0; i < DEPTH; i++)
            tbl.push_back(mk(0,1,0,1,0,0,0,8'h00, 1,DW'(8'h11 * (DEPTH - i)), DEPTH - 1 - i,1, "pop"));
        foreach (tbl[i]) apply(tbl[i]);

        // Underflow and the err set/clear race
        apply(mk(0,0,0,0,0,1,0,8'h00, 0,8'h00, 0,0, "clr_cs0"));
        apply(mk(0,1,0,1,0,0,0,8'h00, 1,8'h00, 0,1, "underflow"));
        apply(mk(0,1,0,0,0,1,0,8'h00, 0,8'h00, 0,0, "clr"));
        apply(mk(0,1,0,1,0,1,0,8'h00, 1,8'h00, 0,1, "underflow_clr"));
        apply(mk(0,1,0,0,0,1,0,8'h00, 0,8'h00, 0,0, "clr2"));
        apply(mk(0,0,1,0,0,0,1,8'h99, 0,8'h00, 0,0, "push_cs0"));

        // Peek holds the top entry; released bus while deselected
        apply(mk(0,1,1,0,0,0,1,8'h5A, 0,8'h00, 1,0, "push5a"));
        apply(mk(0,0,0,1,0,0,1,8'h00, 1,8'h00, 1,0, "release_cs0"));
        for (int i = 0; i < 3; i++)
            apply(mk(0,1,0,1,1,0,0,8'h00, 1,8'h5A, 1,0, "peek"));
        apply(mk(0,1,0,1,0,0,0,8'h00, 1,8'h5A, 0,0, "pop5a"));
        apply(mk(0,1,0,1,1,0,0,8'h00, 1,8'h00, 0,0, "peek_empty"));

        // WE+OE collision: bus left to the external driver, stack untouched
        apply(mk(0,1,1,0,0,0,1,8'h22, 0,8'h00, 1,0, "push22"));
        apply(mk(0,1,1,0,0,0,1,8'h33, 0,8'h00, 2,0, "push33"));
        apply(mk(0,1,1,1,0,0,1,8'h3C, 1,8'h3C, 2,1, "invalid"));
        apply(mk(0,1,0,1,1,0,0,8'h00, 1,8'h33, 2,1, "peek_after_inv"));
        apply(mk(0,1,0,0,0,1,0,8'h00, 0,8'h00, 2,0, "clr3"));

        // Reset during a pop cycle wins over the pop
        apply(mk(0,1,1,0,0,0,1,8'h44, 0,8'h00, 3,0, "push44"));
        apply(mk(0,1,0,1,0,0,0,8'h00, 1,8'h44, 2,0, "pop44"));
        apply(mk(0,1,1,1,0,0,1,8'h3C, 1,8'h3C, 2,1, "invalid2"));
        apply(mk(1,1,0,1,0,0,0,8'h00, 1,8'h33, 0,0, "reset_pop"));
        apply(mk(0,1,0,1,1,0,0,8'h00, 1,8'h00, 0,0, "peek_after_reset"));

        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
